instr_encoder_loader: RTL

//  Inverse of the main decoder path: packs RV32I fields (op, funct3/7, regs, imm) into 32-bit words.

---
 rtl/instr_enc_pkg.sv | 37 +++
 rtl/instr_fifo.sv | 68 ++++++
 rtl/instr_encoder_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types for the RV32I field encoder / IMEM loader.
// Format codes follow the decoder ImmSrc encoding so benches can share one table.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100,
    FMT_R = 3'b111
  } fmt_e;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // True when v[31:lsb] is all zeros or all ones, i.e. v fits as a signed (lsb+1)-bit value.
  function automatic logic upper_same(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] hi;
    hi = v >> lsb;
    return (hi == 32'd0) || (hi == (32'hFFFF_FFFF >> lsb));
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words ahead of the IMEM write port.
// clear empties the FIFO and wins over a same-cycle push or pop.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs RV32I field bundles into instruction words and streams them into IMEM.
//   state    | meaning
//   ST_LOAD  | accepting bundles from the program source
//   ST_DRAIN | last bundle taken, flushing queued words to IMEM
//   ST_DONE  | program fully written, waiting for clear
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int            DEPTH     = 4,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    fmt,
  input  logic [6:0]    op,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [31:0]   imm,
  input  logic          last,
  input  logic          clear,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic [15:0]   words,
  output logic          err,
  output logic          prog_done
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   words_q, words_d;
  logic          err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        fifo_full, fifo_empty;
  logic        accept, push, wr_fire;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word  = {funct7, rs2, rs1, funct3, rd, op};
        enc_legal = 1'b1;
      end
      FMT_I: begin
        enc_word  = {imm[11:0], rs1, funct3, rd, op};
        enc_legal = upper_same(imm, 11);
      end
      FMT_S: begin
        enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        enc_legal = upper_same(imm, 11);
      end
      FMT_B: begin
        enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        enc_legal = upper_same(imm, 12) && !imm[0];
      end
      FMT_U: begin
        enc_word  = {imm[31:12], rd, op};
        enc_legal = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        enc_legal = upper_same(imm, 20) && !imm[0];
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // No bypass: a full FIFO blocks intake even if a pop happens this cycle.
  assign in_ready  = (state_q == ST_LOAD) && !fifo_full;
  assign accept    = in_valid && in_ready && !clear;
  assign push      = accept && enc_legal;
  assign imem_we   = !fifo_empty;
  assign wr_fire   = imem_we && imem_ready && !clear;
  assign imem_addr = addr_q;
  assign words     = words_q;
  assign err       = err_q;
  assign prog_done = (state_q == ST_DONE);

  instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (clear),
    .push  (push),
    .wdata (enc_word),
    .pop   (wr_fire),
    .rdata (imem_wd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    err_d   = err_q;
    if (clear) begin
      state_d = ST_LOAD;
      addr_d  = BASE_ADDR;
      words_d = '0;
      err_d   = 1'b0;
    end else begin
      if (wr_fire) begin
        addr_d = addr_q + AW'(4);
        if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
      end
      if (accept && !enc_legal) err_d = 1'b1;
      case (state_q)
        ST_LOAD:  if (accept && last) state_d = ST_DRAIN;
        ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      addr_q  <= BASE_ADDR;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

endmodule
